// File: rtl/ir_seq_dir_detect.sv
// ir_seq_dir_detect: N-channel IR beam sequence detector with debounce.
// Ordered beam hits give travel direction, an enable and a signed pass count.
module ir_seq_dir_detect #(
   parameter int N_CH    = 3,
   parameter int DEB_CYC = 4,
   parameter int TMO_CYC = 64,
   parameter int CNT_W   = 8
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [N_CH-1:0]  IR,
   input  logic             SW,
   output logic             dir,
   output logic             en,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] pos_cnt
);

   localparam int IW = $clog2(N_CH);
   localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam int TW = $clog2(TMO_CYC + 1);

   typedef enum logic [1:0] {IDLE, FWD, REV, ERR} state_t;

   state_t           State, state_n;
   logic [IW-1:0]    nxt, nxt_n;
   logic [TW-1:0]    tmr, tmr_n;
   logic             dir_n, en_n, done_n, err_n;
   logic [CNT_W-1:0] cnt_n;

   logic [N_CH-1:0]  s1, s2, deb, hit;
   logic [N_CH-1:0]  exp_m, prv_m;
   logic             fwd, last;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         s1 <= '1;
         s2 <= '1;
      end else begin
         s1 <= IR;
         s2 <= s1;
      end
   end

   // hit is registered so it lands on the same edge the level flips
   for (genvar g = 0; g < N_CH; g++) begin : g_deb
      logic [DW-1:0] cnt;
      logic          lvl;
      logic          pls;

      always_ff @(posedge CLK or negedge RSTn) begin
         if (!RSTn) begin
            cnt <= '0;
            lvl <= 1'b1;
            pls <= 1'b0;
         end else begin
            pls <= 1'b0;
            if (s2[g] == lvl) begin
               cnt <= '0;
            end else if (cnt == DW'(DEB_CYC - 1)) begin
               cnt <= '0;
               lvl <= s2[g];
               pls <= lvl;
            end else begin
               cnt <= cnt + DW'(1);
            end
         end
      end

      assign deb[g] = lvl;
      assign hit[g] = pls;
   end

   assign fwd   = (State == FWD);
   assign exp_m = N_CH'(1) << nxt;
   assign prv_m = fwd ? (exp_m >> 1) : (exp_m << 1);
   assign last  = fwd ? (nxt == IW'(N_CH - 1)) : (nxt == '0);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         State   <= IDLE;
         nxt     <= '0;
         tmr     <= '0;
         dir     <= 1'b0;
         en      <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         pos_cnt <= '0;
      end else begin
         State   <= state_n;
         nxt     <= nxt_n;
         tmr     <= tmr_n;
         dir     <= dir_n;
         en      <= en_n;
         done    <= done_n;
         err     <= err_n;
         pos_cnt <= cnt_n;
      end
   end

   always_comb begin
      state_n = State;
      nxt_n   = nxt;
      tmr_n   = tmr;
      dir_n   = dir;
      en_n    = en;
      done_n  = 1'b0;
      err_n   = 1'b0;
      cnt_n   = pos_cnt;
      if (!SW) begin
         state_n = IDLE;
         en_n    = 1'b0;
         tmr_n   = '0;
      end else begin
         unique case (State)
            IDLE: begin
               tmr_n = '0;
               if (!$onehot0(hit)) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else if (hit[0]) begin
                  state_n = FWD;
                  nxt_n   = IW'(1);
               end else if (hit[N_CH-1]) begin
                  state_n = REV;
                  nxt_n   = IW'(N_CH - 2);
               end
            end
            FWD, REV: begin
               tmr_n = tmr + TW'(1);
               if (hit == exp_m) begin
                  tmr_n = '0;
                  if (last) begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                     dir_n   = fwd;
                     en_n    = 1'b1;
                     cnt_n   = fwd ? pos_cnt + CNT_W'(1)
                                   : pos_cnt - CNT_W'(1);
                  end else begin
                     nxt_n = fwd ? nxt + IW'(1) : nxt - IW'(1);
                  end
               end else if (hit != '0 && hit != prv_m) begin
                  state_n = ERR;
                  err_n   = 1'b1;
                  en_n    = 1'b0;
               end else if (tmr_n == TW'(TMO_CYC)) begin
                  state_n = IDLE;
                  err_n   = 1'b1;
                  en_n    = 1'b0;
                  tmr_n   = '0;
               end
            end
            ERR: begin
               tmr_n = '0;
               if (&deb) state_n = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ir_seq_dir_detect.sv
// tb_ir_seq_dir_detect: directed and randomized checks of ir_seq_dir_detect
// against a model built from sample windows and sequence step counts.
module tb_ir_seq_dir_detect;

   localparam int N   = 3;
   localparam int DEB = 4;
   localparam int TMO = 64;

   logic         CLK = 1'b0;
   logic         RSTn;
   logic [N-1:0] IR;
   logic         SW;
   logic         dir, en, done, err;
   logic [7:0]   pos_cnt;

   ir_seq_dir_detect #(
      .N_CH(N), .DEB_CYC(DEB), .TMO_CYC(TMO), .CNT_W(8)
   ) dut (
      .CLK(CLK), .RSTn(RSTn), .IR(IR), .SW(SW),
      .dir(dir), .en(en), .done(done), .err(err), .pos_cnt(pos_cnt)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // model: 0 idle, 1 forward, 2 reverse, 3 error
   int           mode, step, tsince;
   logic         mdir, men, mdone, merr;
   logic [7:0]   mcnt;
   logic [N-1:0] lvl, mhit, d0, d1;
   logic [N-1:0] hist[$];

   int   ndone, nerr;
   logic saw_err, saw_busy;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      mode = 0; step = 0; tsince = 0;
      mdir = 1'b0; men = 1'b0; mdone = 1'b0; merr = 1'b0;
      mcnt = 8'd0;
      lvl = '1; mhit = '0; d0 = '1; d1 = '1;
      hist.delete();
      for (int k = 0; k < DEB; k++) hist.push_back('1);
   endtask

   task automatic model_step();
      logic [N-1:0] h, nh_v;
      int           nh, ex, pv;
      logic         flip;
      h = mhit;
      nh = $countones(h);
      mdone = 1'b0;
      merr = 1'b0;
      if (!SW) begin
         mode = 0; men = 1'b0; tsince = 0;
      end else if (mode == 0) begin
         if (nh > 1) begin
            mode = 3; merr = 1'b1;
         end else if (h[0]) begin
            mode = 1; step = 1; tsince = 0;
         end else if (h[N-1]) begin
            mode = 2; step = 1; tsince = 0;
         end
      end else if (mode == 1 || mode == 2) begin
         tsince++;
         ex = (mode == 1) ? step : N - 1 - step;
         pv = (mode == 1) ? step - 1 : N - step;
         if (nh == 1 && h[ex]) begin
            tsince = 0;
            step++;
            if (step == N) begin
               mdone = 1'b1;
               mdir = (mode == 1);
               men = 1'b1;
               mcnt = (mode == 1) ? mcnt + 8'd1 : mcnt - 8'd1;
               mode = 0;
            end
         end else if (nh > 0 && !(nh == 1 && h[pv])) begin
            merr = 1'b1; men = 1'b0; mode = 3;
         end else if (tsince >= TMO) begin
            merr = 1'b1; men = 1'b0; mode = 0;
         end
      end else begin
         if (&lvl) mode = 0;
      end
      // level flips once the last DEB synced samples all disagree with it
      hist.push_back(d1);
      if (hist.size() > DEB) void'(hist.pop_front());
      nh_v = '0;
      for (int i = 0; i < N; i++) begin
         flip = 1'b1;
         for (int k = 0; k < hist.size(); k++)
            if (hist[k][i] == lvl[i]) flip = 1'b0;
         if (flip) begin
            nh_v[i] = lvl[i];
            lvl[i] = ~lvl[i];
         end
      end
      mhit = nh_v;
      d1 = d0;
      d0 = IR;
   endtask

   task automatic cmp_all();
      chk("dir", 32'(dir), 32'(mdir));
      chk("en", 32'(en), 32'(men));
      chk("done", 32'(done), 32'(mdone));
      chk("err", 32'(err), 32'(merr));
      chk("pos_cnt", 32'(pos_cnt), 32'(mcnt));
      chk("state", 32'(dut.State), 32'(mode));
      chk("done_err_excl", 32'(done & err), 32'd0);
   endtask

   task automatic cyc();
      @(negedge CLK);
      if (RSTn) model_step();
      else model_reset();
      cmp_all();
      if (32'(dut.State) == 32'd3) saw_err = 1'b1;
      if (32'(dut.State) != 32'd0) saw_busy = 1'b1;
      ndone += int'(done);
      nerr += int'(err);
   endtask

   task automatic stagger(input int s0, s1, s2, len, total, swlo, swhi);
      int st[N];
      st[0] = s0; st[1] = s1; st[2] = s2;
      ndone = 0; nerr = 0; saw_err = 1'b0; saw_busy = 1'b0;
      for (int c = 0; c < total; c++) begin
         cyc();
         for (int i = 0; i < N; i++)
            IR[i] = !(st[i] >= 0 && c >= st[i] && c < st[i] + len);
         SW = !(c >= swlo && c < swhi);
      end
   endtask

   initial begin
      int tf, te;
      RSTn = 1'b0;
      SW = 1'b0;
      IR = '1;
      model_reset();
      repeat (3) cyc();
      chk("rst_dir", 32'(dir), 32'd0);
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_cnt", 32'(pos_cnt), 32'd0);
      chk("rst_state", 32'(dut.State), 32'd0);
      RSTn = 1'b1;
      SW = 1'b1;

      stagger(1, 4, 8, 13, 35, -1, -1);
      chk("fwd_done", 32'(ndone), 32'd1);
      chk("fwd_err", 32'(nerr), 32'd0);
      chk("fwd_dir", 32'(dir), 32'd1);
      chk("fwd_en", 32'(en), 32'd1);
      chk("fwd_cnt", 32'(pos_cnt), 32'd1);
      chk("fwd_idle", 32'(dut.State), 32'd0);

      stagger(8, 4, 1, 13, 35, -1, -1);
      chk("rev_done", 32'(ndone), 32'd1);
      chk("rev_dir", 32'(dir), 32'd0);
      chk("rev_en", 32'(en), 32'd1);
      chk("rev_cnt", 32'(pos_cnt), 32'd0);

      stagger(1, -1, -1, 3, 25, -1, -1);
      chk("glitch_busy", 32'(saw_busy), 32'd0);
      chk("glitch_pulses", 32'(ndone + nerr), 32'd0);
      chk("glitch_en", 32'(en), 32'd1);

      ndone = 0; nerr = 0;
      for (int c = 0; c < 40; c++) begin
         cyc();
         if (c == 10) begin
            chk("swd_fwd", 32'(dut.State), 32'd1);
            chk("swd_en_hold", 32'(en), 32'd1);
         end
         if (c == 11) begin
            chk("swd_idle", 32'(dut.State), 32'd0);
            chk("swd_en", 32'(en), 32'd0);
            ndone = 0; nerr = 0;
         end
         IR[0] = !(c >= 1 && c < 14);
         SW = !(c >= 10 && c < 30);
      end
      chk("swd_pulses", 32'(ndone + nerr), 32'd0);

      tf = -1; te = -1; nerr = 0;
      for (int c = 0; c < 110; c++) begin
         cyc();
         if (32'(dut.State) == 32'd1 && tf < 0) tf = c;
         if (err && te < 0) te = c;
         IR[0] = !(c >= 1 && c < 14);
      end
      chk("tmo_gap", 32'(te - tf), 32'd64);
      chk("tmo_nerr", 32'(nerr), 32'd1);
      chk("tmo_en", 32'(en), 32'd0);
      chk("tmo_idle", 32'(dut.State), 32'd0);

      stagger(1, -1, 4, 13, 40, -1, -1);
      chk("skip_err", 32'(nerr), 32'd1);
      chk("skip_errst", 32'(saw_err), 32'd1);
      chk("skip_idle", 32'(dut.State), 32'd0);
      chk("skip_cnt", 32'(pos_cnt), 32'd0);

      stagger(1, 4, 8, 13, 35, -1, -1);
      chk("fwd2_cnt", 32'(pos_cnt), 32'd1);
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (c == 10) chk("rstp_fwd", 32'(dut.State), 32'd1);
         IR[0] = !(c >= 1 && c < 14);
      end
      #2 RSTn = 1'b0;
      #1;
      chk("rstp_dir", 32'(dir), 32'd0);
      chk("rstp_en", 32'(en), 32'd0);
      chk("rstp_pulse", 32'(done | err), 32'd0);
      chk("rstp_cnt", 32'(pos_cnt), 32'd0);
      chk("rstp_state", 32'(dut.State), 32'd0);
      model_reset();
      IR = '1;
      repeat (3) cyc();
      RSTn = 1'b1;
      repeat (10) cyc();

      stagger(8, 4, 1, 13, 35, -1, -1);
      chk("wrap1_cnt", 32'(pos_cnt), 32'hFF);
      chk("wrap1_done", 32'(ndone), 32'd1);
      stagger(8, 4, 1, 13, 35, -1, -1);
      chk("wrap2_cnt", 32'(pos_cnt), 32'hFE);
      chk("wrap2_dir", 32'(dir), 32'd0);

      for (int t = 0; t < 60; t++) begin
         int k, g, ln, lo, hi;
         int s[N];
         k = int'($urandom_range(0, 3));
         g = int'($urandom_range(1, 24));
         ln = int'($urandom_range(1, 16));
         for (int i = 0; i < N; i++) begin
            if (k == 0) s[i] = 1 + i * g;
            else if (k == 1) s[i] = 1 + (N - 1 - i) * g;
            else if ($urandom_range(0, 3) == 0) s[i] = -1;
            else s[i] = int'($urandom_range(0, 40));
         end
         lo = -1; hi = -1;
         if ($urandom_range(0, 4) == 0) begin
            lo = int'($urandom_range(0, 60));
            hi = lo + int'($urandom_range(1, 20));
         end
         stagger(s[0], s[1], s[2], ln, 90, lo, hi);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ir_seq_dir_detect.md
Name: ir_seq_dir_detect

Overview:
- Parametrised successor of the 3-sensor direction detector.
- Watches N_CH active-low IR beam sensors placed in a row along the motor path.
- Reports travel direction, an enable qualifier and a signed pass counter.
- Adds per-channel synchronisation, glitch debounce, inter-sensor timeout, out-of-order error detection and a software enable (SW). It sits between the IR sensor pins and the motor controller.

Parameters:
- N_CH, 3: number of IR channels, >= 2. Channel 0 is the first sensor in forward travel.
- DEB_CYC, 4: consecutive stable samples required to change a debounced level, >= 1.
- TMO_CYC, 64: maximum cycles allowed between successive hits while tracking, >= 2.
- CNT_W, 8: width of the pass counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- IR  in  N_CH  raw sensor inputs, active-low, asynchronous to CLK. Bit i is channel i.
- SW  in  1  detection enable. 0 holds the block idle.
- dir  out  1  direction of the last completed sequence: 1 = forward (0 to N_CH-1), 0 = reverse.
- en  out  1  high while a valid direction is held.
- done  out  1  one-cycle pulse when a sequence completes.
- err  out  1  one-cycle pulse on an order error or a timeout.
- pos_cnt  out  CNT_W  signed pass counter.

Behaviour:
- Reset: asynchronous on RSTn=0. dir=0, en=0, done=0, err=0, pos_cnt=0. State=IDLE. Sync flops and debounced levels = 1 (beams clear). Counters = 0.
- Input path, per channel:
  - 2-flop synchroniser.
  - Debouncer: the debounced level flips only after DEB_CYC consecutive synced samples differ from it. Any agreeing sample clears the count.
  - hit[i]: one-cycle pulse on a debounced 1->0 transition.
  - Latency: hit appears DEB_CYC+2 edges after the first edge that samples IR low.
  - Lows of fewer than DEB_CYC synced cycles never produce a hit.
- FSM register is named State, so benches can probe it. States: IDLE, FWD, REV, ERR. Registers: nxt (expected channel index) and tmr.
- IDLE:
  - hit[0] alone -> FWD, nxt=1, tmr=0.
  - hit[N_CH-1] alone -> REV, nxt=N_CH-2, tmr=0.
  - Hits on middle channels are ignored.
  - Multiple simultaneous hits -> ERR with an err pulse.
- FWD/REV, each cycle tmr increments:
  - hit on nxt alone -> tmr=0, then nxt advances (+1 in FWD, -1 in REV).
  - If that hit is on the final channel (N_CH-1 in FWD, 0 in REV): next cycle done=1, dir=1 for FWD or 0 for REV, en=1, pos_cnt+1 (FWD) or -1 (REV), modulo 2^CNT_W wrap. Then State -> IDLE.
  - A hit on the previously hit channel (re-break) is ignored.
  - Any other hit, or simultaneous hits -> err pulse, en=0, State -> ERR.
  - tmr reaches TMO_CYC -> err pulse, en=0, State -> IDLE.
- ERR: stays in ERR until all debounced levels are 1 for one cycle, then -> IDLE. Hits are ignored.
- SW=0: State forced to IDLE, en=0, tmr cleared, no done/err pulses. dir and pos_cnt are held. Debouncers keep running.
- dir, en and pos_cnt change only as listed above. done and err are never high in the same cycle.
- N_CH=2: a forward sequence completes on hit[1] directly after entry into FWD.

Test Plan:
All scenarios use N_CH=3, DEB_CYC=4, TMO_CYC=64, CNT_W=8, 10 ns clock.
- Release reset, SW=1. IR[0], IR[1], IR[2] each held low 13 cycles, starting 1, 4 and 8 cycles after the start -> one done pulse, dir=1, en=1, pos_cnt=1, State back to IDLE. No err.
- Immediately after, the same stagger in reverse order (IR[2] first) -> done pulse, dir=0, en=1, pos_cnt=0.
- IR[0] low for 3 cycles only -> no hit, State stays IDLE, all outputs unchanged.
- IR[0] low 13 cycles, then nothing -> State=FWD, then an err pulse exactly when tmr reaches 64, en=0, State=IDLE.
- IR[0] then IR[2] (skipping IR[1]) -> err pulse, State=ERR until all sensors are clear, then IDLE. pos_cnt unchanged.
- Two more cases, each starting mid-FWD:
  - SW dropped -> State=IDLE, en=0, no pulses.
  - Separately, RSTn pulsed low -> all outputs 0 immediately and State=IDLE.
- Back-to-back reverse sequences from pos_cnt=0 -> pos_cnt=8'hFF, then 8'hFE (wrap).
